// File: rtl/meep_uart_axil_mailbox.sv
// AXI4-Lite slave exposing a 16550-style register subset over TX/RX byte FIFOs.
module meep_uart_axil_mailbox #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [12:0] REG_BASE   = 13'h1000
) (
  input  logic        chipset_clk,
  input  logic        chipset_rst,
  input  logic [12:0] uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic [12:0] uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic        uart_irq
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = PW + 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [2:0]  SEL_DATA = 3'd0;
  localparam logic [2:0]  SEL_IER  = 3'd1;
  localparam logic [2:0]  SEL_IIR  = 3'd2;
  localparam logic [2:0]  SEL_LSR  = 3'd5;
  localparam logic [2:0]  SEL_SCR  = 3'd7;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

  logic        r_aw_held, r_w_held;
  logic [12:0] r_awaddr;
  logic [7:0]  r_wdata;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [1:0]  r_ier;
  logic [7:0]  r_scr;

  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [12:0] w_aw_off, w_ar_off;
  logic        w_aw_hit, w_ar_hit, w_aw_mapped;
  logic [2:0]  w_aw_sel, w_ar_sel;
  logic        w_commit, w_ar_hs;
  logic [7:0]  w_lsr, w_iir;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic [1:0]  w_wr_resp;
  logic        w_unused;

  // FIFO status from registered pointers only
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[PW] != r_tx_rp[PW]) && (r_tx_wp[PW-1:0] == r_tx_rp[PW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[PW] != r_rx_rp[PW]) && (r_rx_wp[PW-1:0] == r_rx_rp[PW-1:0]);

  // Address decode; offsets below REG_BASE wrap to large values and miss
  assign w_aw_off = r_awaddr - REG_BASE;
  assign w_ar_off = uart_axi_araddr - REG_BASE;
  assign w_aw_hit = (w_aw_off < 13'd32);
  assign w_ar_hit = (w_ar_off < 13'd32);
  assign w_aw_sel = w_aw_off[4:2];
  assign w_ar_sel = w_ar_off[4:2];
  assign w_aw_mapped = w_aw_hit && (w_aw_sel == SEL_DATA || w_aw_sel == SEL_IER ||
                                    w_aw_sel == SEL_IIR  || w_aw_sel == SEL_LSR ||
                                    w_aw_sel == SEL_SCR);

  assign uart_axi_awready = !r_aw_held && !r_bvalid;
  assign uart_axi_wready  = !r_w_held && !r_bvalid;
  assign uart_axi_arready = !r_rvalid;
  assign uart_axi_bvalid  = r_bvalid;
  assign uart_axi_bresp   = r_bresp;
  assign uart_axi_rvalid  = r_rvalid;
  assign uart_axi_rresp   = r_rresp;
  assign uart_axi_rdata   = r_rdata;

  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;
  assign w_ar_hs   = uart_axi_arvalid && !r_rvalid;
  assign w_tx_push = w_commit && w_aw_hit && (w_aw_sel == SEL_DATA) && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && tx_tready;
  assign w_rx_push = rx_tvalid && !w_rx_full;
  assign w_rx_pop  = w_ar_hs && w_ar_hit && (w_ar_sel == SEL_DATA) && !w_rx_empty;

  assign tx_tvalid = !w_tx_empty;
  assign tx_tdata  = r_tx_mem[r_tx_rp[PW-1:0]];
  assign rx_tready = !w_rx_full;

  assign w_lsr    = {1'b0, w_tx_empty, w_tx_empty, 4'b0000, !w_rx_empty};
  assign uart_irq = (r_ier[0] && !w_rx_empty) || (r_ier[1] && w_tx_empty);

  assign w_unused = &{1'b0, uart_axi_wdata[31:8], w_aw_off[1:0], w_ar_off[1:0]};

  // Interrupt identification priority: RX data, then TX empty, else none
  always_comb begin
    w_iir = 8'h01;
    if (r_ier[0] && !w_rx_empty)     w_iir = 8'h04;
    else if (r_ier[1] && w_tx_empty) w_iir = 8'h02;
  end

  // Write response: unmapped or THR-on-full gives SLVERR
  always_comb begin
    w_wr_resp = RESP_OKAY;
    if (!w_aw_mapped)                            w_wr_resp = RESP_SLVERR;
    else if (w_aw_sel == SEL_DATA && w_tx_full)  w_wr_resp = RESP_SLVERR;
  end

  // Read data mux sampled at the AR handshake
  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = RESP_OKAY;
    if (!w_ar_hit) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (w_ar_sel)
        SEL_DATA: if (!w_rx_empty) w_rd_data = {24'd0, r_rx_mem[r_rx_rp[PW-1:0]]};
        SEL_IER:  w_rd_data = {30'd0, r_ier};
        SEL_IIR:  w_rd_data = {24'd0, w_iir};
        SEL_LSR:  w_rd_data = {24'd0, w_lsr};
        SEL_SCR:  w_rd_data = {24'd0, r_scr};
        default:  w_rd_resp = RESP_SLVERR;
      endcase
    end
  end

  // AW/W holding registers, register commit and write response
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= 13'd0;
      r_wdata   <= 8'd0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_ier     <= 2'b00;
      r_scr     <= 8'd0;
    end else begin
      if (uart_axi_awvalid && uart_axi_awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= uart_axi_awaddr;
      end
      if (uart_axi_wvalid && uart_axi_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= uart_axi_wdata[7:0];
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        if (w_aw_hit && w_aw_sel == SEL_IER) r_ier <= r_wdata[1:0];
        if (w_aw_hit && w_aw_sel == SEL_SCR) r_scr <= r_wdata;
      end else if (r_bvalid && uart_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Single outstanding read: capture at AR handshake, hold until rready
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= 32'd0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_resp;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && uart_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // FIFO pointer updates
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_W'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_W'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_W'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_W'(1);
    end
  end

  // FIFO storage writes
  always_ff @(posedge chipset_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[PW-1:0]] <= r_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp[PW-1:0]] <= rx_tdata;
  end

endmodule

// File: doc/meep_uart_axil_mailbox.md
# meep_uart_axil_mailbox

AXI4-Lite slave that terminates the chipset's 13-bit/32-bit UART register port and presents a 16550-style register subset backed by TX and RX byte FIFOs. Sits directly downstream of the OpenPiton chipset UART master. Bytes are exchanged with the host-side console bridge over two byte-stream ports. Drives the level interrupt returned to the chipset as the UART interrupt.

## Interface
- `FIFO_DEPTH`, default 16: depth of each byte FIFO; must be a power of two and ≥2.
- `REG_BASE`, default 13'h1000: address of the THR/RBR register; the register window is `REG_BASE` to `REG_BASE+0x1F`.
- `chipset_clk` in 1: sole clock.
- `chipset_rst` in 1: reset; asynchronous, active-high; clears all state.
- `uart_axi_awaddr` in 13, `uart_axi_awvalid` in 1, `uart_axi_awready` out 1: write address channel.
- `uart_axi_wdata` in 32, `uart_axi_wvalid` in 1, `uart_axi_wready` out 1: write data channel; there is no strobe, so every write is a full word.
- `uart_axi_bresp` out 2, `uart_axi_bvalid` out 1, `uart_axi_bready` in 1: write response channel.
- `uart_axi_araddr` in 13, `uart_axi_arvalid` in 1, `uart_axi_arready` out 1: read address channel.
- `uart_axi_rdata` out 32, `uart_axi_rresp` out 2, `uart_axi_rvalid` out 1, `uart_axi_rready` in 1: read data channel.
- `tx_tdata` out 8, `tx_tvalid` out 1, `tx_tready` in 1: outgoing console bytes.
- `rx_tdata` in 8, `rx_tvalid` in 1, `rx_tready` out 1: incoming console bytes.
- `uart_irq` out 1: level interrupt.

## Operation
- Register map, offsets from `REG_BASE`; address bits [1:0] are ignored.
  - 0x00: read is RBR (pops RX); write is THR (pushes `wdata[7:0]` into TX).
  - 0x04: IER, read/write, bits [1:0] only; bit0 is ERBFI, bit1 is ETBEI.
  - 0x08: IIR, read-only.
    - 0x04 if IER[0] is set and RX is non-empty.
    - Otherwise 0x02 if IER[1] is set and TX is empty.
    - Otherwise 0x01.
  - 0x14: LSR, read-only.
    - bit0 DR = RX non-empty.
    - bit5 THRE = TX empty.
    - bit6 TEMT = TX empty.
    - All other bits 0.
  - 0x1C: SCR, 8-bit read/write scratch.
- Any other address gives SLVERR.
  - A read of an unmapped address returns rdata 0.
  - A write to an unmapped address has no effect.
- THR write while TX is full: the byte is dropped and bresp is SLVERR.
- RBR read while RX is empty: rdata 0, rresp OKAY, no pop.
- Unused rdata bits are 0. Writes to read-only registers return OKAY and are ignored.
- `uart_irq` = (IER[0] & DR) | (IER[1] & THRE).
- Write path:
  - AW and W are captured independently into holding registers.
  - The register write and the FIFO push happen in the cycle after both are held.
  - bvalid rises in that same cycle.
- Read path:
  - One outstanding read.
  - Register contents are sampled at the AR handshake; an RBR pop also happens at the AR handshake.
- `tx_tvalid` = TX non-empty; `tx_tdata` = TX head.
- `rx_tready` = RX not full. RX pushes on rx_tvalid & rx_tready.
- Each FIFO supports a simultaneous push and pop in the same cycle:
  - When full, a pop frees space, but the push in that cycle is still refused. Ready is based on the registered full flag.
  - When empty, a push is not visible to a pop in the same cycle.

## Timing
- Reset values:
  - bvalid, rvalid, tx_tvalid and uart_irq are 0.
  - awready, wready and arready are 1.
  - rx_tready is 1.
  - bresp, rresp and rdata are 0.
  - IER and SCR are 0; both FIFOs are empty.
- `awready` = !aw_held & !bvalid; `wready` = !w_held & !bvalid.
- Write response latency:
  - With AW and W in the same cycle, bvalid is asserted at edge N+2, counting the handshake edge as N+1.
  - bvalid and bresp hold until bready. The holding registers clear when bvalid is set.
- `arready` = !rvalid. rvalid is asserted the cycle after the AR handshake and holds with stable rdata/rresp until rready.
- Back-to-back reads: the next AR is accepted in the cycle after the R handshake.
- The interrupt and LSR reflect FIFO state with no added latency, since they are combinational from registered FIFO pointers.
- Reset asserted mid-transaction: all pending responses are discarded and all FIFO contents are lost.

## Test plan
- Reset, then read LSR at 0x1014: rdata 0x60, rresp OKAY, rvalid one cycle after arready&arvalid.
- Write 0x41, 0x42 to THR with tx_tready=0, then raise tx_tready: tx_tdata emits 0x41 then 0x42 on consecutive cycles; LSR reads 0x00 before release and 0x60 after.
- Fill TX with 16 writes, then write a 17th: bresp is SLVERR; exactly 16 bytes emerge.
- Drive rx_tvalid with 0x5A, set IER=1: uart_irq goes to 1, IIR reads 0x04; an RBR read returns 0x5A, then uart_irq goes to 0 and LSR.DR goes to 0.
- Drive 17 RX bytes with no reads: rx_tready goes low after 16, and the 17th byte is held.
- Present W three cycles before AW, with bready held low for 4 cycles: exactly one write occurs, bvalid holds, and awready/wready stay 0 until bready.
